// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RISC-V field packer with range check, address counter and 2-entry output FIFO
module instr_encoder #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [15:0]       word_count
);

    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
    localparam logic [1:0] FMT_S = 2'b10;

    logic signed [31:0] simm;
    logic [31:0]        enc;
    logic               legal;
    logic               accept;
    logic               push;
    logic               pop;

    logic [31:0]        mem_instr [2];
    logic [ADDR_W-1:0]  mem_addr  [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         count;
    logic [ADDR_W-1:0]  addr_cnt;

    assign simm = $signed(imm);

    always_comb begin
        enc   = '0;
        legal = 1'b1;
        case (fmt)
            FMT_R: enc = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                enc   = {imm[11:0], rs1, funct3, rd, opcode};
                legal = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            FMT_S: begin
                enc   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            default: begin
                enc   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
            end
        endcase
    end

    // Readiness comes only from registered occupancy, so a full FIFO never passes through.
    assign in_ready  = (count < 2'd2) && rst_n;
    assign out_valid = (count != 2'd0);
    assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
    assign out_addr  = out_valid ? mem_addr[rd_ptr] : '0;

    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= enc;
            mem_addr[wr_ptr]  <= addr_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            addr_cnt   <= ADDR_W'(BASE_ADDR);
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            word_count <= 16'd0;
        end else begin
            count     <= count + {1'b0, push} - {1'b0, pop};
            err_pulse <= accept && !legal;
            if (accept && !legal) begin
                err_sticky <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push) begin
                wr_ptr     <= ~wr_ptr;
                addr_cnt   <= addr_cnt + ADDR_W'(4);
                word_count <= word_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder: vector table, corner sequences, random vs model
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid, out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic        err_pulse, err_sticky;
    logic [15:0] word_count;

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [31:0] out_instr2;
    logic [3:0]  out_addr2;
    logic        err_pulse2, err_sticky2;
    logic [15:0] word_count2;

    int checks   = 0;
    int failures = 0;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .word_count(word_count)
    );

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(12)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
        .out_addr(out_addr2), .err_pulse(err_pulse2), .err_sticky(err_sticky2),
        .word_count(word_count2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [6:0]  opc;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        legal;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  addr;
    } entry_t;

    vec_t   tbl[15];
    entry_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        fmt = v.fmt; opcode = v.opc; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm;
    endtask

    // Reference encoding built from bit positions by shift-and-mask arithmetic.
    function automatic logic [31:0] model_enc(input logic [1:0] f, input logic [6:0] opc,
                                              input logic [4:0] d, input logic [4:0] s1,
                                              input logic [4:0] s2, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [31:0] im);
        logic [31:0] w;
        w = 32'(opc) | (32'(f3) << 12);
        case (f)
            2'd0: w = w | (32'(d) << 7) | (32'(s1) << 15) | (32'(s2) << 20) | (32'(f7) << 25);
            2'd1: w = w | (32'(d) << 7) | (32'(s1) << 15) | ((im & 32'hFFF) << 20);
            2'd2: w = w | (32'(s1) << 15) | (32'(s2) << 20)
                        | (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
            default: w = w | (32'(s1) << 15) | (32'(s2) << 20)
                        | (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
                        | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
        endcase
        return w;
    endfunction

    function automatic bit model_legal(input logic [1:0] f, input logic [31:0] im);
        int v;
        v = int'(im);
        if (f == 2'd0) return 1'b1;
        if (f == 2'd3) return (v >= -4096) && (v <= 4094) && ((v & 1) == 0);
        return (v >= -2048) && (v <= 2047);
    endfunction

    initial begin
        int     exp_addr;
        int     exp_wc;
        vec_t   a, b, c;
        logic [31:0] ea, eb, ec;

        tbl[0]  = '{2'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,         1'b1, 32'h00500093};
        tbl[1]  = '{2'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,         1'b1, 32'h0020A423};
        tbl[2]  = '{2'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC,  1'b1, 32'hFE208EE3};
        tbl[3]  = '{2'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,         1'b1, 32'h002081B3};
        tbl[4]  = '{2'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,      1'b0, 32'h0};
        tbl[5]  = '{2'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3,         1'b0, 32'h0};
        tbl[6]  = '{2'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800,  1'b1, 32'h80000093};
        tbl[7]  = '{2'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h7FFFFFFF,  1'b1, 32'h002081B3};
        tbl[8]  = '{2'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,      1'b1, 32'h7E000FE3};
        tbl[9]  = '{2'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF000,  1'b1, 32'h80000063};
        tbl[10] = '{2'd2, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2047,      1'b1, 32'h7E000FA3};
        tbl[11] = '{2'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,      1'b0, 32'h0};
        tbl[12] = '{2'd2, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF7FF,  1'b0, 32'h0};
        tbl[13] = '{2'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2047,      1'b1, 32'h7FF00013};
        tbl[14] = '{2'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,         1'b1, 32'h402081B3};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_valid2 = 1'b0; out_ready2 = 1'b0;
        drive(tbl[0]);
        tick; tick;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_sticky", err_sticky, 0);
        chk("rst_word_count", word_count, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        exp_addr = 0;
        exp_wc   = 0;
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i]);
            in_valid = 1'b1;
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            tick;
            in_valid = 1'b0;
            if (tbl[i].legal) begin
                chk($sformatf("v%0d_out_valid", i), out_valid, 1);
                chk($sformatf("v%0d_out_instr", i), out_instr, tbl[i].exp);
                chk($sformatf("v%0d_out_addr", i), out_addr, 64'(exp_addr));
                chk($sformatf("v%0d_err_pulse", i), err_pulse, 0);
                exp_addr = (exp_addr + 4) & 255;
                exp_wc++;
            end else begin
                chk($sformatf("v%0d_err_pulse", i), err_pulse, 1);
                chk($sformatf("v%0d_out_valid", i), out_valid, 0);
                chk($sformatf("v%0d_err_sticky", i), err_sticky, 1);
            end
            chk($sformatf("v%0d_word_count", i), word_count, 64'(exp_wc));
            tick;
            chk($sformatf("v%0d_err_pulse_gone", i), err_pulse, 0);
            chk($sformatf("v%0d_drained", i), out_valid, 0);
        end

        // Back-to-back rejections give back-to-back pulses.
        a = tbl[4];
        drive(a);
        in_valid = 1'b1;
        tick;
        chk("b2b_err1", err_pulse, 1);
        tick;
        chk("b2b_err2", err_pulse, 1);
        in_valid = 1'b0;
        tick;
        chk("b2b_err_end", err_pulse, 0);
        chk("b2b_wc", word_count, 64'(exp_wc));

        // S, B, R streamed one per cycle.
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(tbl[i]);
            chk($sformatf("stream%0d_in_ready", i), in_ready, 1);
            tick;
            chk($sformatf("stream%0d_instr", i), out_instr, tbl[i].exp);
            chk($sformatf("stream%0d_addr", i), out_addr, 64'(exp_addr));
            exp_addr = (exp_addr + 4) & 255;
            exp_wc++;
        end
        in_valid = 1'b0;
        tick;
        chk("stream_drained", out_valid, 0);

        // Backpressure: two fill the FIFO, third waits for a single pop.
        a = tbl[0]; b = tbl[1]; c = tbl[3];
        ea = tbl[0].exp; eb = tbl[1].exp; ec = tbl[3].exp;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(a); tick;
        drive(b); tick;
        drive(c);
        chk("bp_full_in_ready", in_ready, 0);
        tick;
        chk("bp_still_full", in_ready, 0);
        chk("bp_head_stable", out_instr, ea);
        chk("bp_wc", word_count, 64'(exp_wc + 2));
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("bp_ready_after_pop", in_ready, 1);
        chk("bp_head2", out_instr, eb);
        tick;
        in_valid = 1'b0;
        chk("bp_third_accepted", word_count, 64'(exp_wc + 3));
        chk("bp_full_again", in_ready, 0);
        out_ready = 1'b1;
        chk("bp_drain_b", out_instr, eb);
        chk("bp_drain_b_addr", out_addr, 64'((exp_addr + 4) & 255));
        tick;
        chk("bp_drain_c", out_instr, ec);
        chk("bp_drain_c_addr", out_addr, 64'((exp_addr + 8) & 255));
        tick;
        chk("bp_empty", out_valid, 0);

        // Address wrap on the 4-bit instance.
        drive(tbl[0]);
        in_valid2 = 1'b1;
        tick; tick;
        in_valid2 = 1'b0;
        chk("wrap_addr0", out_addr2, 12);
        out_ready2 = 1'b1;
        tick;
        chk("wrap_valid1", out_valid2, 1);
        chk("wrap_addr1", out_addr2, 0);
        tick;
        out_ready2 = 1'b0;
        chk("wrap_empty", out_valid2, 0);

        // Reset while the FIFO holds two words.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(tbl[0]); tick; tick;
        in_valid = 1'b0;
        chk("mid_full", in_ready, 0);
        rst_n = 1'b0;
        tick;
        chk("mid_rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_err_sticky", err_sticky, 0);
        chk("mid_word_count", word_count, 0);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("mid_next_addr", out_addr, 0);
        chk("mid_next_instr", out_instr, tbl[0].exp);
        out_ready = 1'b1;
        tick;

        // Randomized traffic against the queue model.
        rst_n = 1'b0; in_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        #1;
        q.delete();
        exp_addr = 0;
        exp_wc   = 0;
        for (int n = 0; n < 600; n++) begin
            bit pop_m, acc_m, lg_m;
            entry_t e;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            fmt    = 2'($urandom_range(0, 3));
            opcode = 7'($urandom);
            rd     = 5'($urandom);
            rs1    = 5'($urandom);
            rs2    = 5'($urandom);
            funct3 = 3'($urandom);
            funct7 = 7'($urandom);
            case ($urandom_range(0, 3))
                0: imm = 32'(int'($urandom_range(0, 10000)) - 5000);
                1: imm = $urandom;
                2: imm = 32'(int'($urandom_range(0, 8)) - 4100);
                default: imm = 32'(int'($urandom_range(0, 8)) + 4090);
            endcase

            chk("rnd_in_ready", in_ready, 64'(q.size() < 2));
            chk("rnd_out_valid", out_valid, 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("rnd_out_instr", out_instr, q[0].instr);
                chk("rnd_out_addr", out_addr, q[0].addr);
            end
            pop_m = (q.size() > 0) && out_ready;
            acc_m = in_valid && (q.size() < 2);
            lg_m  = model_legal(fmt, imm);
            e.instr = model_enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
            e.addr  = 8'(exp_addr);
            tick;
            if (pop_m) void'(q.pop_front());
            if (acc_m && lg_m) begin
                q.push_back(e);
                exp_addr = (exp_addr + 4) & 255;
                exp_wc   = (exp_wc + 1) & 16'hFFFF;
            end
            chk("rnd_err_pulse", err_pulse, 64'(acc_m && !lg_m));
            chk("rnd_word_count", word_count, 64'(exp_wc));
        end
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
